uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
- Parametrised UART transmitter; successor to the fixed 8N1 byte transmitter.
- Data width is set at build time.
- Per frame, the block takes a run-time baud divisor, a parity mode (none/even/odd) and a 1- or 2-stop-bit setting.
- Uses a valid/ready handshake with back-to-back frame support.
- Sits between a byte/word source (FIFO or control FSM) and the serial TX pin.

Parameters:
DATA_W, 8, data bits per frame, legal range 5..9, sent LSB first.
DIV_W, 16, width of the baud divisor input.

Ports:
clk  input  1  system clock.
rst  input  1  reset; one clock; reset is synchronous and active-high.
i_data  input  DATA_W  frame payload, sampled on accept.
i_valid  input  1  payload/config valid.
o_ready  output  1  block can accept; a frame is accepted when i_valid and o_ready are both high at a clk edge.
i_baud_div  input  DIV_W  bit period minus one, in clk cycles; sampled on accept.
i_parity  input  2  parity mode, sampled on accept: 0 = none, 1 = even, 2 = odd, 3 = none.
i_stop2  input  1  stop bits, sampled on accept: 0 = one, 1 = two.
o_tx  output  1  serial line; idles high.
o_busy  output  1  frame in progress.
o_done  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (rst high at an edge, takes priority over everything):
  - o_tx=1, o_busy=0, o_ready=1, o_done=0.
  - FSM goes to IDLE; bit counter and divisor counter cleared.
  - Applies mid-frame too: line returns high on the next edge and the frame is abandoned with no o_done.
- o_ready equals !o_busy (combinational).
- While busy, i_valid is ignored and inputs are not sampled.
- On accept, the block registers data, divisor, parity mode and stop setting. Input changes after accept do not affect the frame in flight.
- FSM states: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - PARITY is skipped when mode is 0 or 3.
- Latency and bit timing:
  - The start bit (0) appears on o_tx the cycle after the accept edge.
  - Every bit, including each stop bit, is held for exactly div+1 clk cycles, timed by a divisor counter that counts 0..div.
  - div=0 is legal and gives 1 clk per bit.
- DATA state: sends bit 0 up to bit DATA_W-1; a bit index counter increments at the end of each bit period.
- Parity bit:
  - Computed as the XOR of the registered data.
  - Even mode sends the XOR value; odd mode sends its inverse.
- STOP state: o_tx=1 for one bit period, or two if i_stop2 was set at accept.
- Total frame length is (div+1) × (1 + DATA_W + P + S) clocks, where P is 0 or 1 and S is 1 or 2.
- End of frame:
  - On the edge that ends the final stop period: FSM goes to IDLE, o_busy=0, o_done=1 for exactly one cycle, o_tx stays 1.
  - o_ready is high in the o_done cycle. If i_valid is high then, the next frame is accepted at that edge, and its start bit follows immediately with no idle gap.
- o_busy is 1 from the cycle after accept through the last stop-bit cycle.
- o_tx is always registered (glitch-free).

Test Plan:
- Reset, then DATA_W=8, div=3, parity=0, stop2=0, data=0x55 -> o_tx = 0,1,0,1,0,1,0,1,0,1 each held 4 clk; o_done pulses at clk 40 after accept; o_busy high for 40 cycles.
- div=0, parity=1 (even), data=0x07 -> parity bit 1; frame is 11 clk with 1 clk per bit. Same test with parity=2 (odd) -> parity bit 0.
- stop2=1, parity=0, div=2, data=0xFF -> stop high for 6 clk, o_done at clk 33; i_valid held high with a new word -> second start bit on the cycle right after o_done, no gap.
- Change i_data, i_baud_div and i_parity mid-frame with i_valid high -> frame in flight is unchanged, no second accept until o_ready; o_ready=0 throughout the busy period.
- Assert rst during DATA bit 3 -> o_tx=1 next edge, o_busy=0, o_ready=1, no o_done; the next accepted frame is correct.
- Rebuild with DATA_W=5 and DATA_W=9; data=all ones, odd parity -> correct bit count; odd-parity bit = 0 for 5 and for 9 ones; frame lengths match the formula.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_W data bits LSB first, per-frame baud divisor,
// optional even/odd parity and one or two stop bits, valid/ready handshake.
module uart_tx_cfg #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DIV_W-1:0]  i_baud_div,
    input  logic [1:0]        i_parity,
    input  logic              i_stop2,
    output logic              o_tx,
    output logic              o_busy,
    output logic              o_done
);
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DIV_W-1:0]  div_r;
    logic [DIV_W-1:0]  div_cnt;
    logic [BW-1:0]     bit_cnt;
    logic              par_en;
    logic              par_bit;
    logic              stop2_r;
    logic              bit_end;

    assign bit_end = (div_cnt == div_r);
    assign o_ready = !o_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            o_tx    <= 1'b1;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            o_done <= 1'b0;
            if (state != IDLE)
                div_cnt <= bit_end ? '0 : div_cnt + DIV_W'(1);
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        shreg   <= i_data;
                        div_r   <= i_baud_div;
                        par_en  <= (i_parity == 2'd1) || (i_parity == 2'd2);
                        // parity of the word being registered; odd mode inverts it
                        par_bit <= (^i_data) ^ (i_parity == 2'd2);
                        stop2_r <= i_stop2;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        o_tx    <= 1'b0;
                        o_busy  <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        o_tx  <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == BW'(DATA_W - 1)) begin
                            bit_cnt <= '0;
                            if (par_en) begin
                                o_tx  <= par_bit;
                                state <= PARITY;
                            end else begin
                                o_tx  <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            o_tx    <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        o_tx    <= 1'b1;
                        bit_cnt <= '0;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    // bit_cnt counts stop bits already sent
                    if (bit_end) begin
                        if (stop2_r && bit_cnt == '0) begin
                            bit_cnt <= BW'(1);
                        end else begin
                            bit_cnt <= '0;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: three builds (DATA_W 5, 8, 9) driven in parallel and checked
// every cycle against a waveform-queue model, plus hand-computed frame expectations.
module tb_uart_tx_cfg;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [8:0]  data;
    logic [15:0] div;
    logic [1:0]  par;
    logic        stop2;
    logic [2:0]  tx_v, busy_v, ready_v, done_v;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : lane
        localparam int W = (g == 0) ? 5 : (g == 1) ? 8 : 9;
        uart_tx_cfg #(.DATA_W(W), .DIV_W(16)) dut (
            .clk(clk), .rst(rst), .i_data(data[W-1:0]), .i_valid(valid),
            .o_ready(ready_v[g]), .i_baud_div(div), .i_parity(par), .i_stop2(stop2),
            .o_tx(tx_v[g]), .o_busy(busy_v[g]), .o_done(done_v[g])
        );
    end

    task automatic chk(input string nm, input int l, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got %0d expected %0d", nm, l, act, exp);
        end
    endtask

    // Model: each lane holds a queue of the line level for every remaining frame cycle.
    bit mq[3][$];
    bit mdone[3];
    bit was_idle;

    function automatic void push_frame(int l);
        int w;
        bit x;
        bit bits[$];
        w = (l == 0) ? 5 : (l == 1) ? 8 : 9;
        x = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < w; i++) begin
            bits.push_back(data[i]);
            x ^= data[i];
        end
        if (par == 2'd1 || par == 2'd2) bits.push_back(x ^ (par == 2'd2));
        bits.push_back(1'b1);
        if (stop2) bits.push_back(1'b1);
        foreach (bits[i])
            for (int k = 0; k <= int'(div); k++) mq[l].push_back(bits[i]);
    endfunction

    always @(posedge clk) begin
        for (int l = 0; l < 3; l++) begin
            if (rst) begin
                mq[l].delete();
                mdone[l] = 1'b0;
            end else begin
                was_idle = (mq[l].size() == 0);
                mdone[l] = 1'b0;
                if (!was_idle) begin
                    void'(mq[l].pop_front());
                    mdone[l] = (mq[l].size() == 0);
                end
                if (was_idle && valid) push_frame(l);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int l = 0; l < 3; l++) begin
                chk("tx", l, int'(tx_v[l]), (mq[l].size() != 0) ? int'(mq[l][0]) : 1);
                chk("busy", l, int'(busy_v[l]), int'(mq[l].size() != 0));
                chk("ready", l, int'(ready_v[l]), int'(mq[l].size() == 0));
                chk("done", l, int'(done_v[l]), int'(mdone[l]));
            end
        end
    end

    logic tx_rec[3][0:255];

    task automatic run_frame(input logic [8:0] d, input int dv, input int p, input bit s2,
                             input int e0, input int e1, input int e2, input string nm);
        int lat[3];
        int ex[3];
        bit all;
        ex = '{e0, e1, e2};
        lat = '{-1, -1, -1};
        data = d; div = dv[15:0]; par = p[1:0]; stop2 = s2; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        for (int l = 0; l < 3; l++) tx_rec[l][0] = tx_v[l];
        for (int n = 1; n < 256; n++) begin
            @(negedge clk);
            all = 1'b1;
            for (int l = 0; l < 3; l++) begin
                tx_rec[l][n] = tx_v[l];
                if (done_v[l] && lat[l] < 0) lat[l] = n;
                if (lat[l] < 0) all = 1'b0;
            end
            if (all) break;
        end
        for (int l = 0; l < 3; l++) chk(nm, l, lat[l], ex[l]);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 1000; i++) begin
            if (busy_v == 3'b000 && mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0)
                return;
            @(negedge clk);
        end
        chk("idle_timeout", 0, 1, 0);
    endtask

    int n;
    int hold;

    initial begin
        rst = 1'b1; valid = 1'b0; data = '0; div = '0; par = '0; stop2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        for (int l = 0; l < 3; l++) begin
            chk("rst_tx", l, int'(tx_v[l]), 1);
            chk("rst_busy", l, int'(busy_v[l]), 0);
            chk("rst_ready", l, int'(ready_v[l]), 1);
            chk("rst_done", l, int'(done_v[l]), 0);
        end

        // 0x55, div 3, no parity, one stop: 10 bits x 4 clk for the 8-bit build
        run_frame(9'h055, 3, 0, 1'b0, 28, 40, 44, "lat_55");
        chk("t55_start", 1, int'(tx_rec[1][0]), 0);
        chk("t55_bit0", 1, int'(tx_rec[1][4]), 1);
        chk("t55_bit1", 1, int'(tx_rec[1][8]), 0);
        chk("t55_bit7", 1, int'(tx_rec[1][32]), 0);
        chk("t55_stop", 1, int'(tx_rec[1][36]), 1);

        run_frame(9'h007, 0, 1, 1'b0, 8, 11, 12, "lat_even");
        chk("even_par", 0, int'(tx_rec[0][6]), 1);
        chk("even_par", 1, int'(tx_rec[1][9]), 1);
        chk("even_par", 2, int'(tx_rec[2][10]), 1);
        run_frame(9'h007, 0, 2, 1'b0, 8, 11, 12, "lat_odd");
        chk("odd_par", 0, int'(tx_rec[0][6]), 0);
        chk("odd_par", 1, int'(tx_rec[1][9]), 0);
        chk("odd_par", 2, int'(tx_rec[2][10]), 0);

        run_frame(9'h0FF, 2, 0, 1'b1, 24, 33, 36, "lat_stop2");
        chk("stop2_hi_a", 1, int'(tx_rec[1][27]), 1);
        chk("stop2_hi_b", 1, int'(tx_rec[1][32]), 1);

        // back-to-back: valid held, new word presented in the done cycle
        data = 9'h0FF; div = 16'd2; par = 2'd0; stop2 = 1'b1; valid = 1'b1;
        @(negedge clk);
        for (n = 1; n < 100; n++) begin
            @(negedge clk);
            if (done_v[1]) break;
        end
        chk("b2b_lat", 1, n, 33);
        data = 9'h0A5;
        @(negedge clk);
        chk("b2b_start", 1, int'(tx_v[1]), 0);
        chk("b2b_busy", 1, int'(busy_v[1]), 1);
        valid = 1'b0;
        wait_idle();

        // inputs churn while the 8-bit build is busy
        data = 9'h05A; div = 16'd1; par = 2'd1; stop2 = 1'b0; valid = 1'b1;
        @(negedge clk);
        for (n = 0; n < 100; n++) begin
            if (!busy_v[1]) break;
            chk("ready_low", 1, int'(ready_v[1]), 0);
            data = 9'($urandom); div = 16'($urandom_range(0, 5));
            par = 2'($urandom); stop2 = 1'($urandom);
            @(negedge clk);
        end
        valid = 1'b0;
        chk("churn_len", 1, n, 22);
        wait_idle();

        // reset during data bit 3 of the 8-bit build
        data = 9'h03C; div = 16'd3; par = 2'd0; stop2 = 1'b0; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_rst_busy", 1, int'(busy_v[1]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int l = 0; l < 3; l++) begin
            chk("mrst_tx", l, int'(tx_v[l]), 1);
            chk("mrst_busy", l, int'(busy_v[l]), 0);
            chk("mrst_ready", l, int'(ready_v[l]), 1);
            chk("mrst_done", l, int'(done_v[l]), 0);
        end
        @(negedge clk);
        chk("mrst_nodone", 1, int'(done_v[1]), 0);
        run_frame(9'h0C3, 1, 2, 1'b0, 16, 22, 24, "lat_after_rst");

        // all ones, odd parity: 5 and 9 ones give parity 0, 8 ones gives 1
        run_frame(9'h1FF, 1, 2, 1'b0, 16, 22, 24, "lat_ones");
        chk("ones_par", 0, int'(tx_rec[0][12]), 0);
        chk("ones_par", 1, int'(tx_rec[1][18]), 1);
        chk("ones_par", 2, int'(tx_rec[2][20]), 0);

        for (int it = 0; it < 40; it++) begin
            valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            valid = 1'b1;
            hold = $urandom_range(1, 60);
            repeat (hold) begin
                data = 9'($urandom); div = 16'($urandom_range(0, 4));
                par = 2'($urandom); stop2 = 1'($urandom);
                @(negedge clk);
            end
            valid = 1'b0;
            wait_idle();
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
